// File: rtl/uart_pkg.sv
// Shared definitions for the UART register bank: register addresses, bit indices
// of CTRL/STATUS/IRQ_EN, the sticky error group and a read-word helper.
package uart_pkg;

  localparam logic [3:0] ADDR_CTRL    = 4'h0;
  localparam logic [3:0] ADDR_BAUD_LO = 4'h1;
  localparam logic [3:0] ADDR_BAUD_HI = 4'h2;
  localparam logic [3:0] ADDR_TXDATA  = 4'h3;
  localparam logic [3:0] ADDR_RXDATA  = 4'h4;
  localparam logic [3:0] ADDR_STATUS  = 4'h5;
  localparam logic [3:0] ADDR_IRQ_EN  = 4'h6;
  localparam logic [3:0] ADDR_IRQ_CLR = 4'h7;

  localparam int CTRL_TX_EN      = 0;
  localparam int CTRL_RX_EN      = 1;
  localparam int CTRL_PARITY_EN  = 2;
  localparam int CTRL_PARITY_ODD = 3;
  localparam int CTRL_STOP2      = 4;

  localparam int ST_TX_EMPTY    = 0;
  localparam int ST_TX_FULL     = 1;
  localparam int ST_RX_EMPTY    = 2;
  localparam int ST_RX_FULL     = 3;
  localparam int ST_RX_OVERRUN  = 4;
  localparam int ST_TX_OVERFLOW = 5;
  localparam int ST_PERR_SEEN   = 6;
  localparam int ST_FERR_SEEN   = 7;

  localparam int IRQ_TX_EMPTY    = 0;
  localparam int IRQ_RX_NONEMPTY = 1;
  localparam int IRQ_ERR         = 2;

  // Bit order matches STATUS[7:4] so an IRQ_CLR write mask applies directly.
  typedef struct packed {
    logic ferr_seen;
    logic perr_seen;
    logic tx_overflow;
    logic rx_overrun;
  } sticky_t;

  function automatic logic [10:0] pad_byte(input logic [7:0] b);
    return {3'b000, b};
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with count-based full/empty.
// A push while full is still taken when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap on their own.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/uart_reg_bank.sv
// UART register bank: decodes the 4-bit register map behind the APB slave, holds
// the line configuration, and buffers TX/RX bytes in two FIFOs.
module uart_reg_bank
  import uart_pkg::*;
#(
  parameter int          TX_DEPTH = 8,
  parameter int          RX_DEPTH = 8,
  parameter logic [11:0] BAUD_RST = 12'd27
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        cs,
  input  logic        wm,
  input  logic [3:0]  addr,
  input  logic [7:0]  wdata,
  output logic [10:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_perr,
  input  logic        rx_ferr,
  input  logic        rx_valid,
  output logic        tx_en,
  output logic        rx_en,
  output logic        parity_en,
  output logic        parity_odd,
  output logic        stop2,
  output logic [11:0] baud_div,
  output logic        irq
);

  logic        wr;
  logic        rd;
  logic [4:0]  ctrl;
  logic [7:0]  baud_lo;
  logic [3:0]  baud_hi;
  logic [2:0]  irq_en;
  sticky_t     sticky;
  sticky_t     sticky_set;
  logic [3:0]  irq_clr;

  logic        tx_hit;
  logic        rx_hit;
  logic        tx_hit_d;
  logic        rx_hit_d;
  logic        tx_push;
  logic        tx_pop;
  logic        tx_drop;
  logic        rx_push_req;
  logic        rx_push;
  logic        rx_pop;
  logic        rx_drop;

  logic        tx_full;
  logic        tx_empty;
  logic        rx_full;
  logic        rx_empty;
  logic [9:0]  rx_head;

  logic [7:0]  status;
  logic [2:0]  irq_src;
  logic [10:0] rx_word;
  logic [10:0] rd_word;

  assign wr = cs & wm;
  assign rd = cs & ~wm;

  // TXDATA push / RXDATA pop fire only on the first cycle of a held write.
  assign tx_hit  = wr & (addr == ADDR_TXDATA);
  assign rx_hit  = wr & (addr == ADDR_RXDATA);
  assign tx_push = tx_hit & ~tx_hit_d;
  assign rx_pop  = rx_hit & ~rx_hit_d;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tx_hit_d <= 1'b0;
      rx_hit_d <= 1'b0;
    end else begin
      tx_hit_d <= tx_hit;
      rx_hit_d <= rx_hit;
    end
  end

  // TX stream handshake: a byte moves on every cycle where tx_valid and tx_ready
  // are both high; tx_valid never looks at tx_ready. rx_valid is a one-cycle
  // strobe with no back-pressure, so a full RX FIFO can only drop the byte.
  assign tx_valid = ctrl[CTRL_TX_EN] & ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_drop  = tx_push & tx_full & ~tx_pop;

  assign rx_push_req = rx_valid & ctrl[CTRL_RX_EN];
  assign rx_drop     = rx_push_req & rx_full;
  assign rx_push     = rx_push_req & ~rx_full;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .pclk    (pclk),
    .presetn (presetn),
    .push    (tx_push),
    .pop     (tx_pop),
    .wdata   (wdata),
    .rdata   (tx_data),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  uart_sync_fifo #(
    .WIDTH (10),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .pclk    (pclk),
    .presetn (presetn),
    .push    (rx_push),
    .pop     (rx_pop),
    .wdata   ({rx_ferr, rx_perr, rx_data}),
    .rdata   (rx_head),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  always_comb begin
    sticky_set             = '0;
    sticky_set.rx_overrun  = rx_drop;
    sticky_set.tx_overflow = tx_drop;
    sticky_set.perr_seen   = rx_push & rx_perr;
    sticky_set.ferr_seen   = rx_push & rx_ferr;
  end

  assign irq_clr = (wr && addr == ADDR_IRQ_CLR) ? wdata[7:4] : 4'h0;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ctrl    <= '0;
      baud_lo <= BAUD_RST[7:0];
      baud_hi <= BAUD_RST[11:8];
      irq_en  <= '0;
    end else if (wr) begin
      case (addr)
        ADDR_CTRL:    ctrl    <= wdata[4:0];
        ADDR_BAUD_LO: baud_lo <= wdata;
        ADDR_BAUD_HI: baud_hi <= wdata[3:0];
        ADDR_IRQ_EN:  irq_en  <= wdata[2:0];
        default:      ;
      endcase
    end
  end

  // A new error event wins over a clear landing in the same cycle.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sticky <= '0;
    end else begin
      sticky <= sticky_t'((sticky & ~irq_clr) | sticky_set);
    end
  end

  always_comb begin
    status                 = '0;
    status[ST_TX_EMPTY]    = tx_empty;
    status[ST_TX_FULL]     = tx_full;
    status[ST_RX_EMPTY]    = rx_empty;
    status[ST_RX_FULL]     = rx_full;
    status[ST_RX_OVERRUN]  = sticky.rx_overrun;
    status[ST_TX_OVERFLOW] = sticky.tx_overflow;
    status[ST_PERR_SEEN]   = sticky.perr_seen;
    status[ST_FERR_SEEN]   = sticky.ferr_seen;
  end

  always_comb begin
    irq_src                  = '0;
    irq_src[IRQ_TX_EMPTY]    = tx_empty;
    irq_src[IRQ_RX_NONEMPTY] = ~rx_empty;
    irq_src[IRQ_ERR]         = |status[ST_FERR_SEEN:ST_RX_OVERRUN];
  end

  // An empty RX FIFO reads as all zeros rather than exposing a stale slot.
  assign rx_word = rx_empty ? 11'h000 : {rx_head[9], rx_head[8], 1'b1, rx_head[7:0]};

  always_comb begin
    rd_word = '0;
    case (addr)
      ADDR_CTRL:    rd_word = pad_byte({3'b000, ctrl});
      ADDR_BAUD_LO: rd_word = pad_byte(baud_lo);
      ADDR_BAUD_HI: rd_word = pad_byte({4'h0, baud_hi});
      ADDR_RXDATA:  rd_word = rx_word;
      ADDR_STATUS:  rd_word = pad_byte(status);
      ADDR_IRQ_EN:  rd_word = pad_byte({5'b00000, irq_en});
      default:      rd_word = '0;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rdata <= '0;
      irq   <= 1'b0;
    end else begin
      if (rd) rdata <= rd_word;
      irq <= |(irq_en & irq_src);
    end
  end

  assign tx_en      = ctrl[CTRL_TX_EN];
  assign rx_en      = ctrl[CTRL_RX_EN];
  assign parity_en  = ctrl[CTRL_PARITY_EN];
  assign parity_odd = ctrl[CTRL_PARITY_ODD];
  assign stop2      = ctrl[CTRL_STOP2];
  assign baud_div   = {baud_hi, baud_lo};

endmodule

// File: tb/tb_uart_reg_bank.sv
// Directed scenarios followed by random register/stream traffic, all compared
// against a queue-based model of the register bank kept in this bench.
module tb_uart_reg_bank;

  logic        pclk = 1'b0;
  logic        presetn = 1'b1;
  logic        cs, wm;
  logic [3:0]  addr;
  logic [7:0]  wdata;
  logic [10:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_perr, rx_ferr, rx_valid;
  logic        tx_en, rx_en, parity_en, parity_odd, stop2;
  logic [11:0] baud_div;
  logic        irq;

  int checks = 0;
  int errors = 0;

  uart_reg_bank dut (
    .pclk(pclk), .presetn(presetn), .cs(cs), .wm(wm), .addr(addr), .wdata(wdata),
    .rdata(rdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_valid(rx_valid),
    .tx_en(tx_en), .rx_en(rx_en), .parity_en(parity_en), .parity_odd(parity_odd),
    .stop2(stop2), .baud_div(baud_div), .irq(irq)
  );

  always #5 pclk = ~pclk;

  // Reference model: FIFOs as queues, sticky bits as {ferr,perr,tx_ovf,rx_ovr}.
  logic [7:0]  tx_q[$];
  logic [9:0]  rx_q[$];
  logic [4:0]  m_ctrl;
  logic [7:0]  m_lo;
  logic [3:0]  m_hi;
  logic [2:0]  m_ien;
  logic [3:0]  m_sticky;
  logic [10:0] m_rdata;
  logic        m_irq;
  logic        m_prev_tx, m_prev_rx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    m_ctrl = '0; m_lo = 8'd27; m_hi = '0; m_ien = '0; m_sticky = '0;
    m_rdata = '0; m_irq = 1'b0; m_prev_tx = 1'b0; m_prev_rx = 1'b0;
  endtask

  function automatic logic [7:0] m_status();
    logic txe, txf, rxe, rxf;
    txe = (tx_q.size() == 0) ? 1'b1 : 1'b0;
    txf = (tx_q.size() == 8) ? 1'b1 : 1'b0;
    rxe = (rx_q.size() == 0) ? 1'b1 : 1'b0;
    rxf = (rx_q.size() == 8) ? 1'b1 : 1'b0;
    return {m_sticky, rxf, rxe, txf, txe};
  endfunction

  function automatic logic [10:0] m_read(input logic [3:0] a);
    logic [9:0] h;
    case (a)
      4'h0: return {6'b0, m_ctrl};
      4'h1: return {3'b0, m_lo};
      4'h2: return {7'b0, m_hi};
      4'h4: begin
        if (rx_q.size() == 0) return 11'h000;
        h = rx_q[0];
        return {h[9], h[8], 1'b1, h[7:0]};
      end
      4'h5: return {3'b0, m_status()};
      4'h6: return {8'b0, m_ien};
      default: return 11'h000;
    endcase
  endfunction

  // One clock: advance the model with the current inputs, clock the DUT, compare.
  task automatic step();
    logic wr, rd, tx_pop, tx_push, rx_pop, rx_push, rx_full_pre;
    logic [3:0] clr, set;
    logic [10:0] nxt_rdata;
    logic nxt_irq, m_txv;
    wr = cs & wm;
    rd = cs & ~wm;
    nxt_rdata = rd ? m_read(addr) : m_rdata;
    nxt_irq = |(m_ien & {|m_sticky, (rx_q.size() != 0) ? 1'b1 : 1'b0,
                         (tx_q.size() == 0) ? 1'b1 : 1'b0});
    tx_pop  = m_ctrl[0] && tx_q.size() != 0 && tx_ready;
    tx_push = wr && addr == 4'h3 && !m_prev_tx;
    rx_pop  = wr && addr == 4'h4 && !m_prev_rx;
    rx_push = rx_valid && m_ctrl[1];
    rx_full_pre = (rx_q.size() == 8) ? 1'b1 : 1'b0;
    clr = (wr && addr == 4'h7) ? wdata[7:4] : 4'h0;
    set = 4'h0;
    if (tx_pop) void'(tx_q.pop_front());
    if (tx_push) begin
      if (tx_q.size() < 8) tx_q.push_back(wdata);
      else set[1] = 1'b1;
    end
    if (rx_pop && rx_q.size() != 0) void'(rx_q.pop_front());
    if (rx_push) begin
      if (rx_full_pre) set[0] = 1'b1;
      else begin
        rx_q.push_back({rx_ferr, rx_perr, rx_data});
        set[2] = rx_perr;
        set[3] = rx_ferr;
      end
    end
    m_sticky = (m_sticky & ~clr) | set;
    if (wr) begin
      case (addr)
        4'h0: m_ctrl = wdata[4:0];
        4'h1: m_lo = wdata;
        4'h2: m_hi = wdata[3:0];
        4'h6: m_ien = wdata[2:0];
        default: ;
      endcase
    end
    m_prev_tx = wr && addr == 4'h3;
    m_prev_rx = wr && addr == 4'h4;
    m_rdata = nxt_rdata;
    m_irq = nxt_irq;
    @(posedge pclk);
    #1;
    m_txv = m_ctrl[0] && tx_q.size() != 0;
    check("rdata", 32'(rdata), 32'(m_rdata));
    check("irq", 32'(irq), 32'(m_irq));
    check("tx_valid", 32'(tx_valid), 32'(m_txv));
    if (m_txv) check("tx_data", 32'(tx_data), 32'(tx_q[0]));
    check("baud_div", 32'(baud_div), 32'({m_hi, m_lo}));
    check("ctrl_out", 32'({stop2, parity_odd, parity_en, rx_en, tx_en}), 32'(m_ctrl));
  endtask

  task automatic idle_inputs();
    cs = 0; wm = 0; addr = 0; wdata = 0;
    rx_valid = 0; rx_data = 0; rx_perr = 0; rx_ferr = 0; tx_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    presetn = 1'b1;
    #1;
    presetn = 1'b0;
    model_reset();
    repeat (2) @(posedge pclk);
    #1;
    presetn = 1'b1;
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
    cs = 1; wm = 1; addr = a; wdata = d;
    step();
    cs = 0; wm = 0;
    step();
  endtask

  task automatic rd_reg(input logic [3:0] a);
    cs = 1; wm = 0; addr = a;
    step();
    cs = 0;
  endtask

  task automatic rx_byte(input logic [7:0] d, input logic pe, input logic fe);
    rx_valid = 1; rx_data = d; rx_perr = pe; rx_ferr = fe;
    step();
    rx_valid = 0; rx_perr = 0; rx_ferr = 0;
  endtask

  initial begin
    int ready_pct;
    do_reset();

    // Reset values
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_baud", 32'(baud_div), 32'd27);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    rd_reg(4'h5);
    check("rst_status", 32'(rdata), 32'h005);

    // Held TXDATA write pushes exactly once
    wr_reg(4'h0, 8'h01);
    cs = 1; wm = 1; addr = 4'h3; wdata = 8'hA5;
    repeat (3) step();
    cs = 0; wm = 0;
    step();
    check("hold_tx_data", 32'(tx_data), 32'hA5);
    check("hold_tx_valid", 32'(tx_valid), 32'h1);
    tx_ready = 1;
    step();
    tx_ready = 0;
    rd_reg(4'h5);
    check("hold_tx_empty", 32'(rdata[0]), 32'h1);

    // RX overrun and RXDATA pop
    wr_reg(4'h0, 8'h03);
    for (int i = 0; i < 9; i++) rx_byte(8'h10 + 8'(i), 1'b0, 1'b0);
    rd_reg(4'h5);
    check("ovr_rx_full", 32'(rdata[3]), 32'h1);
    check("ovr_rx_overrun", 32'(rdata[4]), 32'h1);
    rd_reg(4'h4);
    check("rx_head0", 32'(rdata), 32'h110);
    wr_reg(4'h4, 8'h00);
    rd_reg(4'h4);
    check("rx_head1", 32'(rdata), 32'h111);

    // rx_nonempty interrupt
    repeat (7) wr_reg(4'h4, 8'h00);
    rd_reg(4'h5);
    check("drain_rx_empty", 32'(rdata[2]), 32'h1);
    wr_reg(4'h6, 8'h02);
    check("irq_idle", 32'(irq), 32'h0);
    rx_byte(8'h55, 1'b0, 1'b0);
    step();
    step();
    check("irq_rx_set", 32'(irq), 32'h1);
    wr_reg(4'h4, 8'h00);
    check("irq_rx_clr", 32'(irq), 32'h0);

    // Sticky set wins over a same-cycle clear
    rx_valid = 1; rx_data = 8'h66; rx_perr = 1;
    cs = 1; wm = 1; addr = 4'h7; wdata = 8'h40;
    step();
    rx_valid = 0; rx_perr = 0; cs = 0; wm = 0;
    step();
    rd_reg(4'h5);
    check("perr_set_wins", 32'(rdata[6]), 32'h1);
    wr_reg(4'h7, 8'h40);
    rd_reg(4'h5);
    check("perr_cleared", 32'(rdata[6]), 32'h0);
    wr_reg(4'h7, 8'hF0);
    wr_reg(4'h4, 8'h00);

    // Full TX with simultaneous push/pop, then reset mid-stream
    for (int i = 0; i < 8; i++) wr_reg(4'h3, 8'h30 + 8'(i));
    rd_reg(4'h5);
    check("tx_full", 32'(rdata[1]), 32'h1);
    cs = 1; wm = 1; addr = 4'h3; wdata = 8'h99; tx_ready = 1;
    step();
    cs = 0; wm = 0; tx_ready = 0;
    step();
    rd_reg(4'h5);
    check("no_tx_overflow", 32'(rdata[5]), 32'h0);
    check("tx_still_full", 32'(rdata[1]), 32'h1);
    check("tx_head_after_pop", 32'(tx_data), 32'h31);
    tx_ready = 1;
    step();
    presetn = 1'b0;
    #1;
    check("async_rst_tx_valid", 32'(tx_valid), 32'h0);
    check("async_rst_baud", 32'(baud_div), 32'd27);
    idle_inputs();
    model_reset();
    @(posedge pclk);
    #1;
    presetn = 1'b1;
    step();
    rd_reg(4'h5);
    check("post_rst_status", 32'(rdata), 32'h005);

    // Random traffic against the model
    ready_pct = 50;
    for (int n = 0; n < 2000; n++) begin
      if (n % 250 == 0) ready_pct = int'($urandom_range(5, 95));
      if ($urandom_range(0, 3) != 0) begin
        cs = 1'($urandom_range(0, 1));
        wm = 1'($urandom_range(0, 1));
        addr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
        wdata = 8'($urandom_range(0, 255));
      end
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_data = 8'($urandom_range(0, 255));
      rx_perr = ($urandom_range(0, 7) == 0);
      rx_ferr = ($urandom_range(0, 7) == 0);
      tx_ready = ($urandom_range(0, 99) < ready_pct);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
